seq_detector_multi: RTL and testbench

- Multi-pattern serial bitstream detector. Watches a single 1-bit stream qualified by in_valid against NUM_PAT independently programmable patterns.
- Each pattern has its own length, don't-care mask, overlap mode and enable. Each produces a registered match pulse and a saturating hit counter.
- Sits in the stream-monitoring path as the runtime-configurable successor to the fixed single-pattern detector.

---
 rtl/seq_det_pkg.sv | 44 ++++
 rtl/seq_det_lane.sv | 83 ++++++++
 rtl/seq_detector_multi.sv | 72 +++++++
 tb/tb_seq_detector_multi.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the multi-pattern serial detector.
// The lane configuration travels as one flat record: {en, ovl, len, mask, pat}.
package seq_det_pkg;

   localparam int unsigned MAX_SEQ_W = 64;

   function automatic int unsigned len_w(input int unsigned seq_w);
      return $clog2(seq_w + 1);
   endfunction

   function automatic logic [MAX_SEQ_W-1:0] lenmask(input int unsigned len);
      logic [MAX_SEQ_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MAX_SEQ_W; i++) begin
         if (i < len) m[i] = 1'b1;
      end
      return m;
   endfunction

   function automatic int unsigned cfg_pat_lsb(input int unsigned seq_w);
      return 0 * seq_w;
   endfunction

   function automatic int unsigned cfg_mask_lsb(input int unsigned seq_w);
      return seq_w;
   endfunction

   function automatic int unsigned cfg_len_lsb(input int unsigned seq_w);
      return 2 * seq_w;
   endfunction

   function automatic int unsigned cfg_ovl_lsb(input int unsigned seq_w);
      return 2 * seq_w + len_w(seq_w);
   endfunction

   function automatic int unsigned cfg_en_lsb(input int unsigned seq_w);
      return 2 * seq_w + len_w(seq_w) + 1;
   endfunction

   function automatic int unsigned cfg_bits(input int unsigned seq_w);
      return 2 * seq_w + len_w(seq_w) + 2;
   endfunction

endpackage

// File: rtl/seq_det_lane.sv
// One detector lane: configuration registers, fill counter, masked compare,
// registered match pulse and saturating hit counter.
module seq_det_lane
   import seq_det_pkg::*;
#(
   parameter int unsigned SEQ_WIDTH = 8,
   parameter int unsigned CNT_WIDTH = 16,
   localparam int unsigned LEN_W = len_w(SEQ_WIDTH),
   localparam int unsigned CFG_W = cfg_bits(SEQ_WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [SEQ_WIDTH-1:0] win,
   input  logic                 in_valid,
   input  logic                 cfg_wr,
   input  logic [CFG_W-1:0]     cfg,
   input  logic                 cnt_clr,
   output logic                 hit,
   output logic                 match,
   output logic [CNT_WIDTH-1:0] match_cnt
);

   localparam int unsigned PAT_LSB = cfg_pat_lsb(SEQ_WIDTH);
   localparam int unsigned MSK_LSB = cfg_mask_lsb(SEQ_WIDTH);
   localparam int unsigned LEN_LSB = cfg_len_lsb(SEQ_WIDTH);
   localparam int unsigned OVL_LSB = cfg_ovl_lsb(SEQ_WIDTH);
   localparam int unsigned EN_LSB  = cfg_en_lsb(SEQ_WIDTH);

   logic [SEQ_WIDTH-1:0] pat_q;
   logic [SEQ_WIDTH-1:0] mask_q;
   logic [SEQ_WIDTH-1:0] lm;
   logic [LEN_W-1:0]     len_q;
   logic [LEN_W-1:0]     fill_q;
   logic                 ovl_q;
   logic                 en_q;
   logic                 len_ok;
   logic                 filled;
   logic                 cmp_ok;

   always_comb begin
      lm     = SEQ_WIDTH'(lenmask(32'(len_q)));
      len_ok = (len_q != '0) && (32'(len_q) <= SEQ_WIDTH);
      filled = (32'(fill_q) + 32'd1) >= 32'(len_q);
      cmp_ok = ((win ^ pat_q) & mask_q & lm) == '0;
      // A write on this lane wins over a hit in the same cycle.
      hit    = in_valid && en_q && !cfg_wr && len_ok && filled && cmp_ok;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat_q     <= '0;
         mask_q    <= '0;
         len_q     <= '0;
         ovl_q     <= 1'b0;
         en_q      <= 1'b0;
         fill_q    <= '0;
         match     <= 1'b0;
         match_cnt <= '0;
      end else begin
         match <= hit;
         if (cfg_wr) begin
            pat_q  <= cfg[PAT_LSB +: SEQ_WIDTH];
            mask_q <= cfg[MSK_LSB +: SEQ_WIDTH];
            len_q  <= cfg[LEN_LSB +: LEN_W];
            ovl_q  <= cfg[OVL_LSB];
            en_q   <= cfg[EN_LSB];
            fill_q <= '0;
         end else if (in_valid) begin
            if (hit && !ovl_q) begin
               fill_q <= '0;
            end else if (32'(fill_q) < SEQ_WIDTH) begin
               fill_q <= fill_q + 1'b1;
            end
         end
         if (cnt_clr) begin
            match_cnt <= '0;
         end else if (hit && (match_cnt != '1)) begin
            match_cnt <= match_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_detector_multi.sv
// Multi-pattern serial bitstream detector: shared history register feeding
// NUM_PAT independently programmable detector lanes.
module seq_detector_multi
   import seq_det_pkg::*;
#(
   parameter int unsigned SEQ_WIDTH = 8,
   parameter int unsigned NUM_PAT   = 4,
   parameter int unsigned CNT_WIDTH = 16,
   localparam int unsigned IDX_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
   localparam int unsigned LEN_W = len_w(SEQ_WIDTH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic                         in_bit,
   input  logic                         cfg_we,
   input  logic [IDX_W-1:0]             cfg_idx,
   input  logic [SEQ_WIDTH-1:0]         cfg_pat,
   input  logic [SEQ_WIDTH-1:0]         cfg_mask,
   input  logic [LEN_W-1:0]             cfg_len,
   input  logic                         cfg_ovl,
   input  logic                         cfg_en,
   input  logic                         cnt_clr,
   output logic [NUM_PAT-1:0]           match,
   output logic                         any_match,
   output logic [NUM_PAT*CNT_WIDTH-1:0] match_cnt
);

   localparam int unsigned CFG_W = cfg_bits(SEQ_WIDTH);

   // The oldest history bit is shifted out before it can reach any window,
   // so only SEQ_WIDTH-1 bits are stored.
   logic [SEQ_WIDTH-2:0] hist_q;
   logic [SEQ_WIDTH-1:0] win;
   logic [CFG_W-1:0]     cfg_flat;
   logic [NUM_PAT-1:0]   cfg_wr;
   logic [NUM_PAT-1:0]   hit;

   assign win      = {hist_q, in_bit};
   assign cfg_flat = {cfg_en, cfg_ovl, cfg_len, cfg_mask, cfg_pat};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q    <= '0;
         any_match <= 1'b0;
      end else begin
         if (in_valid) hist_q <= win[SEQ_WIDTH-2:0];
         any_match <= |hit;
      end
   end

   for (genvar k = 0; k < NUM_PAT; k++) begin : g_lane
      assign cfg_wr[k] = cfg_we && (cfg_idx == IDX_W'(k));

      seq_det_lane #(
         .SEQ_WIDTH (SEQ_WIDTH),
         .CNT_WIDTH (CNT_WIDTH)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .win       (win),
         .in_valid  (in_valid),
         .cfg_wr    (cfg_wr[k]),
         .cfg       (cfg_flat),
         .cnt_clr   (cnt_clr),
         .hit       (hit[k]),
         .match     (match[k]),
         .match_cnt (match_cnt[k*CNT_WIDTH +: CNT_WIDTH])
      );
   end

endmodule

// File: tb/tb_seq_detector_multi.sv
// Self-checking bench for seq_detector_multi: table vectors, directed corner
// sequences and random traffic against a bit-queue reference model.
module tb_seq_detector_multi;

   localparam int unsigned SW = 8;
   localparam int unsigned NP = 3;
   localparam int unsigned CW = 2;
   localparam int unsigned LW = 4;
   localparam int unsigned IW = 2;
   localparam int unsigned CMAX = (1 << CW) - 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0, in_bit = 1'b0, cfg_we = 1'b0;
   logic [IW-1:0]  cfg_idx = '0;
   logic [SW-1:0]  cfg_pat = '0, cfg_mask = '0;
   logic [LW-1:0]  cfg_len = '0;
   logic           cfg_ovl = 1'b0, cfg_en = 1'b0, cnt_clr = 1'b0;
   logic [NP-1:0]  match;
   logic           any_match;
   logic [NP*CW-1:0] match_cnt;

   always #5 clk = ~clk;

   seq_detector_multi #(
      .SEQ_WIDTH (SW),
      .NUM_PAT   (NP),
      .CNT_WIDTH (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .cfg_we    (cfg_we),
      .cfg_idx   (cfg_idx),
      .cfg_pat   (cfg_pat),
      .cfg_mask  (cfg_mask),
      .cfg_len   (cfg_len),
      .cfg_ovl   (cfg_ovl),
      .cfg_en    (cfg_en),
      .cnt_clr   (cnt_clr),
      .match     (match),
      .any_match (any_match),
      .match_cnt (match_cnt)
   );

   // Reference model: the full stream as a queue (front = newest) and, per
   // lane, how many valid bits have arrived since the lane last restarted.
   bit          hq[$];
   int unsigned m_pat[NP], m_mask[NP], m_len[NP], fresh[NP], cnt[NP];
   bit          m_ovl[NP], m_en[NP];
   logic [NP-1:0] exp_m;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input int act, input int exp);
      if (act != exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      hq.delete();
      for (int k = 0; k < NP; k++) begin
         m_pat[k] = 0; m_mask[k] = 0; m_len[k] = 0;
         m_ovl[k] = 0; m_en[k] = 0; fresh[k] = 0; cnt[k] = 0;
      end
      exp_m = '0;
   endtask

   function automatic bit bit_ago(input int unsigned i);
      if (i == 0) return in_bit;
      if (i - 1 < hq.size()) return hq[i-1];
      return 1'b0;
   endfunction

   task automatic model_step();
      logic [NP-1:0] h;
      h = '0;
      for (int k = 0; k < NP; k++) begin
         bit wr, ok;
         wr = cfg_we && (int'(cfg_idx) == k);
         if (in_valid && m_en[k] && !wr && m_len[k] >= 1 && m_len[k] <= SW &&
             fresh[k] + 1 >= m_len[k]) begin
            ok = 1;
            for (int unsigned i = 0; i < m_len[k]; i++) begin
               if (((m_mask[k] >> i) & 1) != 0 && bit_ago(i) != ((m_pat[k] >> i) & 1))
                  ok = 0;
            end
            h[k] = ok;
         end
      end
      for (int k = 0; k < NP; k++) begin
         if (cfg_we && int'(cfg_idx) == k) begin
            m_pat[k] = cfg_pat; m_mask[k] = cfg_mask; m_len[k] = cfg_len;
            m_ovl[k] = cfg_ovl; m_en[k] = cfg_en; fresh[k] = 0;
         end else if (in_valid) begin
            fresh[k] = (h[k] && !m_ovl[k]) ? 0 : fresh[k] + 1;
         end
         if (cnt_clr) cnt[k] = 0;
         else if (h[k] && cnt[k] < CMAX) cnt[k]++;
      end
      if (in_valid) begin
         hq.push_front(in_bit);
         if (hq.size() > 64) void'(hq.pop_back());
      end
      exp_m = h;
   endtask

   task automatic check_model();
      n_vec++;
      chk("match", int'(match), int'(exp_m));
      chk("any_match", int'(any_match), int'(|exp_m));
      for (int k = 0; k < NP; k++)
         chk($sformatf("cnt%0d", k), int'(match_cnt[k*CW +: CW]), int'(cnt[k]));
   endtask

   // One clock: model sees the pre-edge inputs, DUT is sampled 1 ns after.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_model();
      in_valid = 0; cfg_we = 0; cnt_clr = 0;
   endtask

   task automatic bitin(input logic b);
      in_valid = 1; in_bit = b;
      cycle();
   endtask

   task automatic idle();
      in_valid = 0; in_bit = 0;
      cycle();
   endtask

   task automatic set_cfg(input int idx, input int pat, input int mask, input int len,
                          input bit ovl, input bit en);
      cfg_we = 1; cfg_idx = IW'(idx); cfg_pat = SW'(pat); cfg_mask = SW'(mask);
      cfg_len = LW'(len); cfg_ovl = ovl; cfg_en = en;
   endtask

   task automatic write_cfg(input int idx, input int pat, input int mask, input int len,
                            input bit ovl, input bit en);
      set_cfg(idx, pat, mask, len, ovl, en);
      cycle();
   endtask

   task automatic do_reset();
      rst = 1; in_valid = 0; cfg_we = 0; cnt_clr = 0;
      #1;
      model_reset();
      check_model();
      @(posedge clk);
      #1;
      check_model();
      rst = 0;
   endtask

   task automatic send4(input logic [3:0] s);
      for (int i = 3; i >= 0; i--) bitin(s[i]);
   endtask

   typedef struct {
      bit b;
      bit m_ovl;
      int c_ovl;
      bit m_non;
      int c_non;
   } vec_t;

   vec_t tbl[7];
   int   sat_exp[6];

   initial begin
      tbl[0] = '{1, 0, 0, 0, 0};
      tbl[1] = '{0, 0, 0, 0, 0};
      tbl[2] = '{0, 0, 0, 0, 0};
      tbl[3] = '{1, 1, 1, 1, 1};
      tbl[4] = '{0, 0, 1, 0, 1};
      tbl[5] = '{0, 0, 1, 0, 1};
      tbl[6] = '{1, 1, 2, 0, 1};
      sat_exp = '{1, 2, 3, 3, 3, 3};

      do_reset();

      // Pattern 1001 on lane 0, overlapping then non-overlapping.
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         write_cfg(0, 'h9, 'hFF, 4, pass == 0, 1);
         for (int i = 0; i < 7; i++) begin
            bitin(tbl[i].b);
            chk("tbl_match0", int'(match[0]), pass == 0 ? int'(tbl[i].m_ovl) : int'(tbl[i].m_non));
            chk("tbl_cnt0", int'(match_cnt[0 +: CW]), pass == 0 ? tbl[i].c_ovl : tbl[i].c_non);
         end
      end

      // Don't-care bit 2 on lane 1.
      begin
         logic [3:0] streams[3];
         bit         want[3];
         streams = '{4'b1101, 4'b1001, 4'b0101};
         want    = '{1, 1, 0};
         for (int s = 0; s < 3; s++) begin
            do_reset();
            write_cfg(1, 'b1101, 'b1011, 4, 1, 1);
            send4(streams[s]);
            chk("mask_match1", int'(match[1]), int'(want[s]));
         end
      end

      // Invalid gaps between bits are transparent.
      do_reset();
      write_cfg(0, 'h9, 'hF, 4, 1, 1);
      begin
         logic [3:0] s;
         s = 4'b1001;
         for (int i = 3; i >= 0; i--) begin
            bitin(s[i]);
            chk("gap_match0", int'(match[0]), int'(i == 0));
            for (int g = 0; g < 3; g++) begin
               idle();
               chk("gap_idle0", int'(match[0]), 0);
            end
         end
      end

      // 2-bit counter saturation, then cnt_clr against a same-cycle hit.
      do_reset();
      write_cfg(2, 1, 1, 1, 1, 1);
      for (int i = 0; i < 6; i++) begin
         bitin(1);
         chk("sat_cnt2", int'(match_cnt[2*CW +: CW]), sat_exp[i]);
      end
      cnt_clr = 1;
      bitin(1);
      chk("clr_cnt2", int'(match_cnt[2*CW +: CW]), 0);
      chk("clr_match2", int'(match[2]), 1);

      // Config write on the completing bit suppresses the hit.
      do_reset();
      write_cfg(0, 'h9, 'hF, 4, 1, 1);
      bitin(1); bitin(0); bitin(0);
      set_cfg(0, 'h9, 'hF, 4, 1, 1);
      bitin(1);
      chk("cfgwr_match0", int'(match[0]), 0);
      bitin(0); bitin(0); bitin(1);

      // Reset in the middle of a pattern.
      do_reset();
      write_cfg(0, 'h9, 'hF, 4, 1, 1);
      bitin(1); bitin(0); bitin(0);
      do_reset();
      write_cfg(0, 'h9, 'hF, 4, 1, 1);
      bitin(1);
      chk("rstmid_match0", int'(match[0]), 0);

      // Zero and over-long lengths never match; out-of-range index is ignored.
      do_reset();
      write_cfg(0, 0, 0, 0, 1, 1);
      write_cfg(1, 0, 0, 9, 1, 1);
      write_cfg(2, 'h9, 'hF, 4, 1, 1);
      write_cfg(3, 0, 0, 1, 1, 1);
      for (int i = 0; i < 10; i++) bitin(1'($urandom));
      send4(4'b1001);
      chk("idx_oob_match", int'(match), 3'b100);

      // Random traffic with occasional reconfiguration and counter clears.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0)
            set_cfg($urandom_range(0, 3), $urandom, $urandom_range(0, 7) == 0 ? 'hFF : $urandom,
                    $urandom_range(0, 10), 1'($urandom), $urandom_range(0, 5) != 0);
         in_valid = $urandom_range(0, 3) != 0;
         in_bit   = 1'($urandom);
         cnt_clr  = $urandom_range(0, 49) == 0;
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
